axi_burst_splitter: RTL and testbench

//  Command front-end sitting directly upstream of axi_burst_master's user control port.

---
 rtl/axi_burst_splitter_if.sv | 46 ++++
 rtl/axi_burst_splitter.sv | 125 ++++++++++++
 tb/tb_axi_burst_splitter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_splitter_if.sv
// Bus bundle between a command source, the burst splitter and the downstream
// burst master. The splitter uses the slave view; a command source that also
// plays the burst master (e.g. a testbench) uses the master view.
interface axi_burst_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) ();
    // Command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_w_r;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [CNT_W-1:0]      cmd_beats;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;
    logic                  busy;
    logic                  done;
    logic                  err;
    // Burst master side
    logic                  user_start;
    logic                  user_w_r;
    logic [7:0]            user_burst_len_in;
    logic [ADDR_W-1:0]     user_addr_in;
    logic [DATA_W-1:0]     user_data_in;
    logic [DATA_W/8-1:0]   user_data_strb;
    logic                  user_free;
    logic [1:0]            user_status;
    logic                  user_data_out_valid;

    modport slave (
        input  cmd_valid, cmd_w_r, cmd_addr, cmd_beats, cmd_wdata, cmd_wstrb,
        output cmd_ready, busy, done, err,
        output user_start, user_w_r, user_burst_len_in, user_addr_in,
        output user_data_in, user_data_strb,
        input  user_free, user_status, user_data_out_valid
    );

    modport master (
        output cmd_valid, cmd_w_r, cmd_addr, cmd_beats, cmd_wdata, cmd_wstrb,
        input  cmd_ready, busy, done, err,
        input  user_start, user_w_r, user_burst_len_in, user_addr_in,
        input  user_data_in, user_data_strb,
        output user_free, user_status, user_data_out_valid
    );
endinterface

// File: rtl/axi_burst_splitter.sv
// Splits one large read or fill-write command into AXI INCR bursts of at most
// MAX_BEATS beats that never cross a 4 KB boundary, and hands them one at a
// time to the burst master through a user_start/user_free handshake.
module axi_burst_splitter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_burst_splitter_if.slave   bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int SH    = $clog2(BYTES);
    localparam int W     = CNT_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SH) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ISSUE, S_GAP, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nx;

    logic                 accept;
    logic                 issue;
    logic [ADDR_W-1:0]    addr_q;
    logic [CNT_W-1:0]     rem_q;
    logic [W-1:0]         blen_q;
    logic [W-1:0]         b4k;
    logic [W-1:0]         blen;
    logic                 err_q;
    logic                 w_r_q;
    logic [7:0]           len_q;
    logic [ADDR_W-1:0]    uaddr_q;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W/8-1:0]  strb_q;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Beats left before the next 4 KB page, and the size of the burst to issue.
    // Everything is held at CNT_W+1 bits so a full page or MAX_BEATS=256 never truncates.
    assign b4k  = W'((13'd4096 - {1'b0, addr_q[11:0]}) >> SH);
    assign blen = min3({1'b0, rem_q}, W'(MAX_BEATS), b4k);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.cmd_valid)
                         state_nx = (bus.cmd_beats == '0) ? S_DONE : S_CALC;
            S_CALC:  state_nx = S_ISSUE;
            S_ISSUE: if (bus.user_free) state_nx = S_GAP;
            S_GAP:   state_nx = (rem_q == '0) ? S_DRAIN : S_CALC;
            S_DRAIN: if (bus.user_free) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore/handshake outputs decoded from the current state
    always_comb begin
        bus.cmd_ready  = (state == S_IDLE);
        bus.busy       = (state != S_IDLE);
        bus.done       = (state == S_DONE);
        bus.user_start = (state == S_ISSUE) && bus.user_free;
        accept         = (state == S_IDLE) && bus.cmd_valid;
        issue          = (state == S_ISSUE) && bus.user_free;
    end

    // Command latch, burst walk and sticky error
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            err_q   <= 1'b0;
            w_r_q   <= 1'b0;
            len_q   <= '0;
            uaddr_q <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            if (accept) begin
                w_r_q  <= bus.cmd_w_r;
                addr_q <= bus.cmd_addr & ALIGN_MASK;
                rem_q  <= bus.cmd_beats;
                data_q <= bus.cmd_wdata;
                strb_q <= bus.cmd_w_r ? '0 : bus.cmd_wstrb;
                err_q  <= 1'b0;
            end else if ((state != S_IDLE) && bus.user_data_out_valid && bus.user_status[1]) begin
                err_q  <= 1'b1;
            end
            if (state == S_CALC) begin
                blen_q  <= blen;
                uaddr_q <= addr_q;
                len_q   <= 8'(blen - W'(1));
            end
            if (issue) begin
                addr_q <= addr_q + (ADDR_W'(blen_q) << SH);
                rem_q  <= rem_q - CNT_W'(blen_q);
            end
        end
    end

    assign bus.err               = err_q;
    assign bus.user_w_r          = w_r_q;
    assign bus.user_burst_len_in = len_q;
    assign bus.user_addr_in      = uaddr_q;
    assign bus.user_data_in      = data_q;
    assign bus.user_data_strb    = strb_q;

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Bench for axi_burst_splitter: directed scenarios plus random commands, with a
// simple responsive burst master and an arithmetic model of the burst split.
module tb_axi_burst_splitter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int CNT_W     = 16;
    localparam int MAX_BEATS = 256;
    localparam int BUDGET    = 3000;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    logic aclk = 1'b0;
    logic areset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    burst_t exp_q[$];

    always #5 aclk = ~aclk;

    axi_burst_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    axi_burst_splitter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference split: walk the command page by page with plain arithmetic.
    task automatic build_model(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, n, b4k;
        burst_t b;
        exp_q.delete();
        a   = addr & ~32'h7;
        rem = beats;
        while (rem > 0) begin
            b4k = (4096 - int'(a[11:0])) / 8;
            n = rem;
            if (n > MAX_BEATS) n = MAX_BEATS;
            if (n > b4k) n = b4k;
            b.addr = a;
            b.len  = n - 1;
            exp_q.push_back(b);
            a   = a + 32'(n * 8);
            rem = rem - n;
        end
    endtask

    // Offer a command and return at the first sample point after it was accepted.
    task automatic accept(input logic w_r, input logic [31:0] addr, input int beats,
                          input logic [63:0] data, input logic [7:0] strb);
        @(posedge aclk); #1;
        bus.cmd_w_r   = w_r;
        bus.cmd_addr  = addr;
        bus.cmd_beats = 16'(beats);
        bus.cmd_wdata = data;
        bus.cmd_wstrb = strb;
        bus.cmd_valid = 1'b1;
        @(negedge aclk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge aclk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge aclk);
    endtask

    // Run one command to completion against the model.
    task automatic run_cmd(input logic w_r, input logic [31:0] addr, input int beats,
                           input logic [63:0] data, input logic [7:0] strb,
                           input int err_idx, input int hold);
        int nexp, nstart, ndone, drop, cyc;
        bit inj, exp_err, started;
        logic [7:0] estrb;
        build_model(addr, beats);
        nexp    = exp_q.size();
        nstart  = 0;
        ndone   = 0;
        drop    = 0;
        cyc     = 0;
        inj     = 1'b0;
        exp_err = 1'b0;
        estrb   = w_r ? 8'h00 : strb;
        bus.user_free = (hold > 0) ? 1'b0 : 1'b1;
        accept(w_r, addr, beats, data, strb);
        chk("err_cleared_on_accept", bus.err, 0);
        chk("done_latency", bus.done, (beats == 0) ? 1 : 0);
        chk("busy_after_accept", bus.busy, 1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_no_start", bus.user_start, 0);
            if (i >= 1 && nexp > 0) begin
                chk("hold_addr", bus.user_addr_in, exp_q[0].addr);
                chk("hold_len", bus.user_burst_len_in, 64'(exp_q[0].len));
            end
            @(posedge aclk); #1;
            @(negedge aclk);
        end
        forever begin
            started = bus.user_start;
            if (started) begin
                nstart++;
                if (exp_q.size() == 0) begin
                    chk("extra_start", 64'(nstart), 64'(nexp));
                end else begin
                    chk("burst_addr", bus.user_addr_in, exp_q[0].addr);
                    chk("burst_len", bus.user_burst_len_in, 64'(exp_q[0].len));
                    chk("burst_w_r", bus.user_w_r, w_r);
                    chk("burst_data", bus.user_data_in, data);
                    chk("burst_strb", bus.user_data_strb, estrb);
                    void'(exp_q.pop_front());
                end
                if (nstart - 1 == err_idx) inj = 1'b1;
                drop = int'($urandom_range(0, 4));
            end
            if (bus.done) begin
                ndone++;
                break;
            end
            cyc++;
            if (cyc > BUDGET) begin
                chk("timeout_done", 64'(ndone), 1);
                break;
            end
            @(posedge aclk); #1;
            if (started) bus.user_free = 1'b1;
            else if (drop > 0) begin
                bus.user_free = 1'b0;
                drop--;
            end else bus.user_free = 1'b1;
            if (inj) begin
                bus.user_data_out_valid = 1'b1;
                bus.user_status         = 2'b10;
                inj     = 1'b0;
                exp_err = 1'b1;
            end else begin
                bus.user_data_out_valid = ($urandom_range(0, 3) == 0);
                bus.user_status         = {1'b0, 1'($urandom_range(0, 1))};
            end
            @(negedge aclk);
        end
        chk("burst_count", 64'(nstart), 64'(nexp));
        chk("err_at_done", bus.err, exp_err);
        @(posedge aclk); #1;
        bus.user_data_out_valid = 1'b0;
        bus.user_status         = 2'b00;
        bus.user_free           = 1'b1;
        @(negedge aclk);
        chk("done_one_cycle", bus.done, 0);
        chk("cmd_ready_after_done", bus.cmd_ready, 1);
        chk("err_held_idle", bus.err, exp_err);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_start"}, bus.user_start, 0);
        chk({tag, "_w_r"}, bus.user_w_r, 0);
        chk({tag, "_len"}, bus.user_burst_len_in, 0);
        chk({tag, "_addr"}, bus.user_addr_in, 0);
        chk({tag, "_data"}, bus.user_data_in, 0);
        chk({tag, "_strb"}, bus.user_data_strb, 0);
    endtask

    initial begin
        int nstart_after;
        areset                  = 1'b1;
        bus.cmd_valid           = 1'b0;
        bus.cmd_w_r             = 1'b0;
        bus.cmd_addr            = '0;
        bus.cmd_beats           = '0;
        bus.cmd_wdata           = '0;
        bus.cmd_wstrb           = '0;
        bus.user_free           = 1'b1;
        bus.user_status         = 2'b00;
        bus.user_data_out_valid = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk_reset_values("reset");

        // Write crossing a page: (0xFE0, len 3) then (0x1000, len 5)
        run_cmd(1'b0, 32'h0000_0FE0, 10, 64'hDEAD_BEEF_0123_4567, 8'hF0, -1, 0);
        // Long read: lens 255, 255, 87 at 0x0, 0x800, 0x1000
        run_cmd(1'b1, 32'h0000_0000, 600, 64'h1111_2222_3333_4444, 8'hFF, -1, 0);
        // Zero-beat command
        run_cmd(1'b0, 32'h0000_1234, 0, 64'h5, 8'h0F, -1, 0);
        // user_free held low through ISSUE
        run_cmd(1'b0, 32'h0000_2008, 40, 64'hA5A5_A5A5_5A5A_5A5A, 8'h3C, -1, 21);
        // Error reported during the second burst
        run_cmd(1'b1, 32'h0000_0000, 600, 64'h0, 8'hFF, 1, 0);
        // Next command must clear err
        run_cmd(1'b0, 32'hFFFF_FFC0, 20, 64'h7777, 8'h81, -1, 0);

        // Reset in GAP of a 3-burst read
        bus.user_free = 1'b1;
        accept(1'b1, 32'h0, 600, 64'h0, 8'hFF);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_test_first_start", bus.user_start, 1);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_test_in_gap_busy", bus.busy, 1);
        areset = 1'b1;
        @(negedge aclk);
        chk_reset_values("midrst");
        areset = 1'b0;
        nstart_after = 0;
        repeat (30) begin
            @(negedge aclk);
            if (bus.user_start) nstart_after++;
        end
        chk("no_start_after_reset", 64'(nstart_after), 0);

        // Random commands
        for (int k = 0; k < 12; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if (k % 2 == 0) ra[11:0] = 12'(4096 - 8 * $urandom_range(1, 40));
            run_cmd(1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 700)),
                    {$urandom, $urandom}, 8'($urandom),
                    int'($urandom_range(0, 5)) - 2, int'($urandom_range(0, 1)) * 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
